// File: rtl/hwpe_stream_serialize_sidech_if.sv
// Minimal valid/ready stream bundle (data + byte strobes) used on both sides
// of the serializer.
interface hwpe_stream_serialize_sidech_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport sink (
        input  valid,
        input  data,
        input  strb,
        output ready
    );

    modport source (
        output valid,
        output data,
        output strb,
        input  ready
    );

endinterface

// File: rtl/hwpe_stream_serialize_sidech.sv
// Wide-to-narrow stream serializer: buffers one wide word plus its side-channel
// tag and emits it LSB slice first, tagging every beat and flagging the last one.
module hwpe_stream_serialize_sidech #(
    parameter int unsigned DATA_WIDTH_IN  = 64,
    parameter int unsigned DATA_WIDTH_OUT = 16,
    parameter int unsigned SIDECH_WIDTH   = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    hwpe_stream_serialize_sidech_if.sink      push_i,
    input  logic [SIDECH_WIDTH-1:0]           sidech_i,
    hwpe_stream_serialize_sidech_if.source    pop_o,
    output logic [SIDECH_WIDTH-1:0]           sidech_o,
    output logic                              last_o
);

    localparam int unsigned NB_BEATS = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int unsigned CNT_W    = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;
    localparam int unsigned STRB_IN  = DATA_WIDTH_IN / 8;
    localparam int unsigned STRB_OUT = DATA_WIDTH_OUT / 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_BEATS - 1);

    if (((DATA_WIDTH_IN % DATA_WIDTH_OUT) != 0) || ((DATA_WIDTH_OUT % 8) != 0))
    begin : gen_bad_params
        $error("DATA_WIDTH_IN must be a multiple of DATA_WIDTH_OUT, itself a multiple of 8");
    end

    typedef enum logic {StIdle, StSer} state_e;

    state_e                     r_state;
    state_e                     w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [DATA_WIDTH_IN-1:0]   r_data;
    logic [STRB_IN-1:0]         r_strb;
    logic [SIDECH_WIDTH-1:0]    r_sidech;

    logic                       w_load;
    logic                       w_last;
    logic                       w_pop_valid;
    logic                       w_push_ready;

    logic [DATA_WIDTH_OUT-1:0]  w_beat_data [NB_BEATS];
    logic [STRB_OUT-1:0]        w_beat_strb [NB_BEATS];

    for (genvar k = 0; k < NB_BEATS; k++) begin : gen_slice
        assign w_beat_data[k] = r_data[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
        assign w_beat_strb[k] = r_strb[k*STRB_OUT +: STRB_OUT];
    end

    assign w_last = (r_cnt == LAST_CNT);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_load       = 1'b0;
        w_pop_valid  = 1'b0;
        w_push_ready = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_push_ready = 1'b1;
                if (push_i.valid) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StSer;
                end
            end
            StSer: begin
                w_pop_valid = 1'b1;
                // Accepting on the final beat's pop keeps the output free of bubbles.
                w_push_ready = pop_o.ready & w_last;
                if (pop_o.ready) begin
                    if (!w_last) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else if (push_i.valid) begin
                        w_load    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_data   <= '0;
            r_strb   <= '0;
            r_sidech <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_data   <= push_i.data;
                r_strb   <= push_i.strb;
                r_sidech <= sidech_i;
            end
        end
    end

    assign push_i.ready = w_push_ready;
    assign pop_o.valid  = w_pop_valid;
    assign pop_o.data   = w_pop_valid ? w_beat_data[r_cnt] : '0;
    assign pop_o.strb   = w_pop_valid ? w_beat_strb[r_cnt] : '0;
    assign sidech_o     = w_pop_valid ? r_sidech : '0;
    assign last_o       = w_pop_valid & w_last;

endmodule

// File: tb/tb_hwpe_stream_serialize_sidech.sv
// Randomized scoreboard bench for hwpe_stream_serialize_sidech (64 -> 16 bit, 1-bit tag).
module tb_hwpe_stream_serialize_sidech;

    localparam int DIN = 64;
    localparam int DOUT = 16;
    localparam int NB = DIN / DOUT;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [0:0] sidech_in;
    logic [0:0] sidech_out;
    logic       last_out;

    always #5 clk = ~clk;

    hwpe_stream_serialize_sidech_if #(.DATA_WIDTH(DIN))  push_if ();
    hwpe_stream_serialize_sidech_if #(.DATA_WIDTH(DOUT)) pop_if ();

    hwpe_stream_serialize_sidech #(
        .DATA_WIDTH_IN  (DIN),
        .DATA_WIDTH_OUT (DOUT),
        .SIDECH_WIDTH   (1)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clear),
        .push_i   (push_if),
        .sidech_i (sidech_in),
        .pop_o    (pop_if),
        .sidech_o (sidech_out),
        .last_o   (last_out)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  strb;
        logic        sc;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    mode = 0;
    int    fired = 0;
    int    run = 0;
    int    max_run = 0;
    logic  held = 1'b0;
    beat_t held_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a wide word is just NB slices, low slice first, tag on each.
    task automatic model_push(input logic [63:0] d, input logic [7:0] s, input logic sc);
        beat_t b;
        for (int k = 0; k < NB; k++) begin
            b.data = 16'(d >> (DOUT * k));
            b.strb = 2'(s >> (2 * k));
            b.sc   = sc;
            b.last = (k == NB - 1);
            exp_q.push_back(b);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        beat_t cur;
        forever begin
            @(negedge clk);
            if (rst || clear) begin
                exp_q.delete();
                held = 1'b0;
                run = 0;
                continue;
            end
            cur = {pop_if.data, pop_if.strb, sidech_out, last_out};
            if (held) check("stable_while_stalled", 64'({pop_if.valid, cur}), 64'({1'b1, held_b}));
            if (!pop_if.valid) begin
                check("idle_outputs_zero", 64'(cur), 64'd0);
                check("idle_push_ready", 64'(push_if.ready), 64'd1);
                run = 0;
            end else begin
                run++;
                if (run > max_run) max_run = run;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_beat: got %h expected none at %0t", cur, $time);
                end else begin
                    check("push_ready", 64'(push_if.ready), 64'(pop_if.ready & exp_q[0].last));
                    if (pop_if.ready) begin
                        check("beat", 64'(cur), 64'(exp_q.pop_front()));
                        fired++;
                    end
                end
            end
            held = pop_if.valid & ~pop_if.ready;
            held_b = cur;
            if (push_if.valid && push_if.ready) model_push(push_if.data, push_if.strb, sidech_in);
        end
    end

    // Downstream ready: 0 always high, 1 pattern 1,0,0, 2 random
    initial begin
        int phase = 0;
        pop_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1: begin
                    pop_if.ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                2: pop_if.ready = 1'($urandom_range(0, 1));
                default: pop_if.ready = 1'b1;
            endcase
        end
    end

    task automatic push_word(input logic [63:0] d, input logic [7:0] s, input logic sc);
        int n = 0;
        push_if.valid = 1'b1;
        push_if.data = d;
        push_if.strb = s;
        sidech_in = sc;
        do begin
            @(negedge clk);
            n++;
        end while (!push_if.ready && n < 200);
        if (!push_if.ready) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got ready=0 expected ready=1 at %0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pop_if.valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int f0;
        rst = 1'b1;
        clear = 1'b0;
        push_if.valid = 1'b1;
        push_if.data = {$urandom, $urandom};
        push_if.strb = 8'hFF;
        sidech_in = 1'b1;

        // 1: reset with push valid held high
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_valid", 64'(pop_if.valid), 64'd0);
            check("rst_outputs", 64'({pop_if.data, pop_if.strb, sidech_out, last_out}), 64'd0);
            check("rst_push_ready", 64'(push_if.ready), 64'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_if.valid = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_valid", 64'(pop_if.valid), 64'd0);
        @(posedge clk);
        #1;

        // 2: single word, first beat one cycle after the push
        mode = 0;
        push_word(64'h4444_3333_2222_1111, 8'hFF, 1'b1);
        push_if.valid = 1'b0;
        @(negedge clk);
        check("latency_valid", 64'(pop_if.valid), 64'd1);
        check("latency_data", 64'(pop_if.data), 64'h1111);
        drain();

        // 3: back-to-back words, no bubbles
        max_run = 0;
        f0 = fired;
        for (int i = 0; i < 3; i++) push_word({$urandom, $urandom}, 8'($urandom), 1'($urandom));
        push_if.valid = 1'b0;
        drain();
        check("b2b_run", 64'(max_run), 64'd12);
        check("b2b_beats", 64'(fired - f0), 64'd12);

        // 4: backpressure 1,0,0
        mode = 1;
        for (int i = 0; i < 3; i++) push_word({$urandom, $urandom}, 8'($urandom), 1'($urandom));
        push_if.valid = 1'b0;
        drain();

        // 5: clear after two beats, next word starts fresh
        mode = 0;
        push_word(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b1);
        push_if.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("clear_valid", 64'(pop_if.valid), 64'd0);
        @(posedge clk);
        #1;
        push_word(64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0);
        push_if.valid = 1'b0;
        @(negedge clk);
        check("clear_new_beat0", 64'({pop_if.data, sidech_out}), 64'({16'hCDEF, 1'b0}));
        drain();

        // 6: strobe split with an all-zero beat
        f0 = fired;
        push_word(64'h1234_5678_9ABC_DEF0, 8'b0110_0001, 1'b1);
        push_if.valid = 1'b0;
        drain();
        check("strb_split_beats", 64'(fired - f0), 64'd4);

        // Random traffic with random backpressure and gaps
        mode = 2;
        f0 = fired;
        for (int i = 0; i < 30; i++) begin
            push_word({$urandom, $urandom}, 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                push_if.valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        push_if.valid = 1'b0;
        drain();
        check("random_beats", 64'(fired - f0), 64'(30 * NB));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
